mem_port_arbiter: RTL and testbench

//  Shares the single slot-indexed data memory and its TLB between fetch (port 0) and load/store (port 1).
//  - Configures the TLB base once after reset.
//  - Arbitrates the two requesters round-robin and range-checks each address.
//  - Sequences the memory access with fixed latency and returns one response per request.
//  - Sits between the core pipeline and the TLB/memory pair.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slot-indexed data memory and its TLB between a fetch port
//   (port 0, read-only) and a load/store port (port 1). After reset it pulses
//   the TLB reset once with the base address. It then grants the two
//   requesters round-robin and range-checks each address. Each granted access
//   runs through a fixed-latency memory sequence and returns exactly one
//   response to the requesting port.
//
// Ports
//   i_clk, i_reset                clock, async active-low reset
//   i_req0_valid/i_req0_vptr      fetch request     -> o_req0_ready
//   o_rsp0_valid/rdata/err        fetch response (1-cycle strobe, data held)
//   i_req1_valid/vptr/we/wdata    LSU request       -> o_req1_ready
//   o_rsp1_valid/rdata/err        LSU response (also for writes, rdata=0)
//   o_tlb_reset, o_tlb_vptr       TLB init pulse and translated address
//   o_mem_en/we/wdata, i_mem_rdata memory strobe and data
module mem_port_arbiter #(
    parameter int unsigned MEM_SLOTS_COUNT = 32,
    parameter logic [31:0] BASE_VPTR       = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_vptr,
    output logic        o_req0_ready,
    output logic        o_rsp0_valid,
    output logic [31:0] o_rsp0_rdata,
    output logic        o_rsp0_err,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_vptr,
    input  logic        i_req1_we,
    input  logic [31:0] i_req1_wdata,
    output logic        o_req1_ready,
    output logic        o_rsp1_valid,
    output logic [31:0] o_rsp1_rdata,
    output logic        o_rsp1_err,
    output logic        o_tlb_reset,
    output logic [31:0] o_tlb_vptr,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [31:0] WINDOW = 32'(4 * MEM_SLOTS_COUNT);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_tlb_reset;
    logic          r_last_grant;
    logic          r_port;
    logic          r_we;
    logic [31:0]   r_vptr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rsp0_rdata, r_rsp1_rdata;
    logic          r_rsp0_err, r_rsp1_err;

    logic          w_gnt0, w_gnt1, w_accept, w_sel, w_sel_we, w_fault, w_last_beat;
    logic [31:0]   w_sel_vptr, w_off, w_rdata;

    // On a tie the port that did not win last time gets the grant.
    assign w_gnt0     = (r_state == S_IDLE) && i_req0_valid && (!i_req1_valid || r_last_grant);
    assign w_gnt1     = (r_state == S_IDLE) && i_req1_valid && (!i_req0_valid || !r_last_grant);
    assign w_accept   = w_gnt0 || w_gnt1;
    assign w_sel      = w_gnt1;
    assign w_sel_vptr = w_sel ? i_req1_vptr : i_req0_vptr;
    assign w_sel_we   = w_sel && i_req1_we;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign w_off       = w_sel_vptr - BASE_VPTR;
    assign w_fault     = (w_sel_vptr[1:0] != 2'b00) || (w_off >= WINDOW);
    assign w_last_beat = (r_state == S_ACCESS) && (r_cnt == CNT_LAST);
    assign w_rdata     = r_we ? 32'h0 : i_mem_rdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   if (r_tlb_reset) w_state_nxt = S_IDLE;
            S_IDLE:   if (w_accept) w_state_nxt = w_fault ? S_RESP : S_ACCESS;
            S_ACCESS: if (w_last_beat) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_INIT;
            r_tlb_reset  <= 1'b0;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_vptr       <= BASE_VPTR;
            r_wdata      <= 32'h0;
            r_cnt        <= '0;
            r_rsp0_rdata <= 32'h0;
            r_rsp1_rdata <= 32'h0;
            r_rsp0_err   <= 1'b0;
            r_rsp1_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // One-cycle TLB init pulse while still in INIT, then move to IDLE.
            r_tlb_reset <= (r_state == S_INIT) && !r_tlb_reset;

            if (w_accept) begin
                r_port       <= w_sel;
                r_last_grant <= w_sel;
                r_vptr       <= w_sel_vptr;
                r_we         <= w_sel_we;
                r_wdata      <= w_sel ? i_req1_wdata : 32'h0;
                r_cnt        <= '0;
                // Faults skip the memory: the response registers load now.
                if (w_fault) begin
                    if (w_sel) begin
                        r_rsp1_rdata <= 32'h0;
                        r_rsp1_err   <= 1'b1;
                    end else begin
                        r_rsp0_rdata <= 32'h0;
                        r_rsp0_err   <= 1'b1;
                    end
                end
            end

            if ((r_state == S_ACCESS) && !w_last_beat)
                r_cnt <= r_cnt + CW'(1);

            if (w_last_beat) begin
                if (r_port) begin
                    r_rsp1_rdata <= w_rdata;
                    r_rsp1_err   <= 1'b0;
                end else begin
                    r_rsp0_rdata <= w_rdata;
                    r_rsp0_err   <= 1'b0;
                end
            end
        end
    end

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_rsp0_valid = (r_state == S_RESP) && !r_port;
    assign o_rsp1_valid = (r_state == S_RESP) && r_port;
    assign o_rsp0_rdata = r_rsp0_rdata;
    assign o_rsp0_err   = r_rsp0_err;
    assign o_rsp1_rdata = r_rsp1_rdata;
    assign o_rsp1_err   = r_rsp1_err;
    assign o_tlb_reset  = r_tlb_reset;
    assign o_tlb_vptr   = r_vptr;
    // Strobe only on the first ACCESS cycle; write controls are gated by it.
    assign o_mem_en     = (r_state == S_ACCESS) && (r_cnt == '0);
    assign o_mem_we     = o_mem_en && r_we;
    assign o_mem_wdata  = o_mem_en ? r_wdata : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a LAT=1 instance with a scoreboard and a
// memory model, plus a LAT=3 instance for latency timing.
module tb_mem_port_arbiter;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int SLOTS = 32;

    typedef struct {logic [31:0] rdata; logic err;} rsp_t;
    typedef struct {logic we; logic [31:0] vptr; logic [31:0] wdata;} acc_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int   cyc = 0, checks = 0, errors = 0, tlb_run = 0, tlb_pulses = 0;

    logic v0 = 0, v1 = 0, we1 = 0;
    logic [31:0] p0 = 0, p1 = 0, wd1 = 0, mrd;
    logic rdy0, rdy1, rv0, rv1, er0, er1, tlbr, men, mwe;
    logic [31:0] rd0, rd1, tlbv, mwd;

    logic v03 = 0;
    logic [31:0] p03 = 0, mrd3;
    logic rdy03, rdy13, rv03, rv13, er03, er13, tlbr3, men3, mwe3;
    logic [31:0] rd03, rd13, tlbv3, mwd3;

    rsp_t q0[$], q1[$];
    acc_t qa[$];
    int   order[$];
    logic [31:0] mem1[SLOTS], refm[SLOTS];

    mem_port_arbiter #(.MEM_SLOTS_COUNT(SLOTS), .BASE_VPTR(BASE), .MEM_LATENCY(1)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0_valid(v0), .i_req0_vptr(p0), .o_req0_ready(rdy0),
        .o_rsp0_valid(rv0), .o_rsp0_rdata(rd0), .o_rsp0_err(er0),
        .i_req1_valid(v1), .i_req1_vptr(p1), .i_req1_we(we1), .i_req1_wdata(wd1),
        .o_req1_ready(rdy1), .o_rsp1_valid(rv1), .o_rsp1_rdata(rd1), .o_rsp1_err(er1),
        .o_tlb_reset(tlbr), .o_tlb_vptr(tlbv),
        .o_mem_en(men), .o_mem_we(mwe), .o_mem_wdata(mwd), .i_mem_rdata(mrd));

    mem_port_arbiter #(.MEM_SLOTS_COUNT(SLOTS), .BASE_VPTR(BASE), .MEM_LATENCY(3)) dut3 (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0_valid(v03), .i_req0_vptr(p03), .o_req0_ready(rdy03),
        .o_rsp0_valid(rv03), .o_rsp0_rdata(rd03), .o_rsp0_err(er03),
        .i_req1_valid(1'b0), .i_req1_vptr(32'h0), .i_req1_we(1'b0), .i_req1_wdata(32'h0),
        .o_req1_ready(rdy13), .o_rsp1_valid(rv13), .o_rsp1_rdata(rd13), .o_rsp1_err(er13),
        .o_tlb_reset(tlbr3), .o_tlb_vptr(tlbv3),
        .o_mem_en(men3), .o_mem_we(mwe3), .o_mem_wdata(mwd3), .i_mem_rdata(mrd3));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic bit tb_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(4 * SLOTS));
    endfunction

    // LAT=1 memory model + response/access scoreboard + TLB pulse width.
    initial forever begin
        acc_t a;
        rsp_t r;
        logic [4:0] ix;
        @(negedge clk);
        if (!rst_n) begin
            mrd = 32'hDEAD_BEEF;
            tlb_run = 0;
        end else begin
            if (tlbr) tlb_run++;
            else if (tlb_run != 0) begin
                checks++; tlb_pulses++;
                if (tlb_run != 1) begin errors++; $display("FAIL tlb_pulse_width got=%0d exp=1", tlb_run); end
                tlb_run = 0;
            end
            if (men) begin
                checks++;
                if (qa.size() == 0) begin errors++; $display("FAIL mem_en unexpected vptr=%h", tlbv); end
                else begin
                    a = qa.pop_front();
                    if (mwe !== a.we || tlbv !== a.vptr || (a.we && mwd !== a.wdata)) begin
                        errors++;
                        $display("FAIL mem_access got we=%b vptr=%h wdata=%h exp we=%b vptr=%h wdata=%h",
                                 mwe, tlbv, mwd, a.we, a.vptr, a.wdata);
                    end
                end
                ix = 5'((tlbv - BASE) >> 2);
                if (mwe) mem1[ix] = mwd;
                mrd = mem1[ix];
            end else mrd = 32'hBAD0_0000 | 32'(cyc[15:0]);
            if (rv0) begin
                checks++;
                if (q0.size() == 0) begin errors++; $display("FAIL rsp0 unexpected rdata=%h", rd0); end
                else begin
                    r = q0.pop_front();
                    if (rd0 !== r.rdata || er0 !== r.err) begin
                        errors++; $display("FAIL rsp0 got=%h/%b exp=%h/%b", rd0, er0, r.rdata, r.err);
                    end
                end
            end
            if (rv1) begin
                checks++;
                if (q1.size() == 0) begin errors++; $display("FAIL rsp1 unexpected rdata=%h", rd1); end
                else begin
                    r = q1.pop_front();
                    if (rd1 !== r.rdata || er1 !== r.err) begin
                        errors++; $display("FAIL rsp1 got=%h/%b exp=%h/%b", rd1, er1, r.rdata, r.err);
                    end
                end
            end
        end
    end

    // LAT=3 memory model: data is presented only in the third cycle after mem_en.
    initial forever begin
        int pend3, cnt3;
        logic [4:0] ix3;
        @(negedge clk);
        if (!rst_n) begin pend3 = 0; cnt3 = 0; ix3 = 0; mrd3 = 32'h0; end
        else begin
            if (men3) begin pend3 = 1; cnt3 = 2; ix3 = 5'((tlbv3 - BASE) >> 2); end
            else if (pend3 != 0) cnt3--;
            if (pend3 != 0 && cnt3 == 0) begin mrd3 = 32'h3333_0000 | 32'(ix3); pend3 = 0; end
            else mrd3 = 32'hBAD3_0000 | 32'(cyc[15:0]);
        end
    end

    task automatic req0(input logic [31:0] a);
        rsp_t r;
        acc_t e;
        logic [4:0] ix;
        @(posedge clk); #1; v0 = 1; p0 = a;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (rdy0) break; end
        checks++;
        if (!rdy0) begin errors++; $display("FAIL req0_accept got=timeout exp=accept vptr=%h", a); end
        else begin
            order.push_back(0);
            ix = 5'((a - BASE) >> 2);
            if (tb_fault(a)) begin r.rdata = 32'h0; r.err = 1'b1; end
            else begin
                r.rdata = refm[ix]; r.err = 1'b0;
                e.we = 1'b0; e.vptr = a; e.wdata = 32'h0; qa.push_back(e);
            end
            q0.push_back(r);
        end
    endtask

    task automatic req1(input logic [31:0] a, input logic we, input logic [31:0] wd);
        rsp_t r;
        acc_t e;
        logic [4:0] ix;
        @(posedge clk); #1; v1 = 1; p1 = a; we1 = we; wd1 = wd;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (rdy1) break; end
        checks++;
        if (!rdy1) begin errors++; $display("FAIL req1_accept got=timeout exp=accept vptr=%h", a); end
        else begin
            order.push_back(1);
            ix = 5'((a - BASE) >> 2);
            if (tb_fault(a)) begin r.rdata = 32'h0; r.err = 1'b1; end
            else begin
                r.err = 1'b0;
                if (we) begin refm[ix] = wd; r.rdata = 32'h0; end
                else r.rdata = refm[ix];
                e.we = we; e.vptr = a; e.wdata = wd; qa.push_back(e);
            end
            q1.push_back(r);
        end
    endtask

    task automatic test_reset();
        bit seen;
        v0 = 1; p0 = BASE + 8; v1 = 1; p1 = BASE + 16; we1 = 1; wd1 = 32'h1234;
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, rv0, rv1, tlbr, men, mwe} !== 7'b0 || mwd !== 0 || rd0 !== 0 || rd1 !== 0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0", {rdy0, rdy1, rv0, rv1, tlbr, men, mwe});
        end
        checks++;
        if (tlbv !== BASE) begin errors++; $display("FAIL reset_tlb_vptr got=%h exp=%h", tlbv, BASE); end
        @(posedge clk); #1; rst_n = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (tlbr) begin seen = 1; break; end end
        checks++;
        if (!seen) begin errors++; $display("FAIL init_tlb_reset got=0 exp=1"); end
        else begin
            checks++;
            if (rdy0 !== 0 || rdy1 !== 0 || tlbv !== BASE) begin
                errors++; $display("FAIL init_cycle got rdy=%b%b vptr=%h exp rdy=00 vptr=%h", rdy0, rdy1, tlbv, BASE);
            end
        end
    endtask

    task automatic test_alternate();
        fork
            begin req0(BASE + 8); req0(BASE + 12); @(posedge clk); #1; v0 = 0; end
            begin req1(BASE + 16, 1'b1, 32'h1234); req1(BASE + 16, 1'b0, 32'h0); @(posedge clk); #1; v1 = 0; end
        join
        checks++;
        if (order.size() != 4) begin errors++; $display("FAIL grant_count got=%0d exp=4", order.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != (i % 2)) begin errors++; $display("FAIL grant_order[%0d] got=%0d exp=%0d", i, order[i], i % 2); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read();
        mem1[2] = 32'hCAFE_F00D; refm[2] = 32'hCAFE_F00D;
        req0(BASE + 8);
        @(posedge clk); #1; v0 = 0;
        @(negedge clk);
        checks++;
        if (men !== 1 || tlbv !== BASE + 8 || rv0 !== 0) begin
            errors++; $display("FAIL read_t1 got en=%b vptr=%h rv=%b exp en=1 vptr=%h rv=0", men, tlbv, rv0, BASE + 8);
        end
        @(negedge clk);
        checks++;
        if (rv0 !== 1 || rd0 !== 32'hCAFE_F00D || er0 !== 0) begin
            errors++; $display("FAIL read_t2 got rv=%b rdata=%h err=%b exp rv=1 rdata=cafef00d err=0", rv0, rd0, er0);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fault();
        logic [31:0] addrs[3];
        addrs[0] = BASE + 32'(4 * SLOTS); addrs[1] = BASE - 4; addrs[2] = BASE + 2;
        for (int k = 0; k < 3; k++) begin
            req1(addrs[k], 1'b0, 32'h0);
            @(posedge clk); #1; v1 = 0;
            @(negedge clk);
            checks++;
            if (rv1 !== 1 || er1 !== 1 || rd1 !== 0 || men !== 0) begin
                errors++; $display("FAIL fault_%h got rv=%b err=%b rdata=%h en=%b exp rv=1 err=1 rdata=0 en=0",
                                   addrs[k], rv1, er1, rd1, men);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_latency3();
        bit got;
        @(posedge clk); #1; v03 = 1; p03 = BASE + 20;
        got = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (rdy03) begin got = 1; break; end end
        checks++;
        if (!got) begin errors++; $display("FAIL lat3_accept got=timeout exp=accept"); end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) p03 = BASE + 24;
            @(negedge clk);
            checks++;
            if (men3 !== (k == 1) || rv03 !== (k == 4) || rdy03 !== (k == 5)) begin
                errors++; $display("FAIL lat3_T+%0d got en=%b rv=%b rdy=%b", k, men3, rv03, rdy03);
            end
            if (k == 4) begin
                checks++;
                if (rd03 !== 32'h3333_0005 || er03 !== 0) begin
                    errors++; $display("FAIL lat3_rdata got=%h/%b exp=33330005/0", rd03, er03);
                end
            end
        end
        @(posedge clk); #1; v03 = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (rv03) begin got = 1; break; end end
        checks++;
        if (!got || rd03 !== 32'h3333_0006) begin
            errors++; $display("FAIL lat3_second got=%h seen=%b exp=33330006", rd03, got);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int rv_seen;
        req0(BASE + 4);
        @(posedge clk); #1; v0 = 0;
        @(negedge clk);
        checks++;
        if (men !== 1) begin errors++; $display("FAIL rstmid_access got en=%b exp=1", men); end
        #1; rst_n = 0;
        #1;
        checks++;
        if ({rdy0, rdy1, rv0, rv1, tlbr, men, mwe} !== 7'b0 || mwd !== 0 || rd0 !== 0 || er0 !== 0 || tlbv !== BASE) begin
            errors++; $display("FAIL rstmid_outputs got=%b rd0=%h vptr=%h exp=0 rd0=0 vptr=%h",
                               {rdy0, rdy1, rv0, rv1, tlbr, men, mwe}, rd0, tlbv, BASE);
        end
        q0.delete(); qa.delete();
        repeat (2) @(posedge clk);
        #1; rst_n = 1;
        seen = 0; rv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tlbr) seen = 1;
            if (rv0 || rv1) rv_seen++;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_init_replay got=0 exp=1"); end
        checks++;
        if (rv_seen != 0) begin errors++; $display("FAIL rstmid_dropped_rsp got=%0d exp=0", rv_seen); end
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) begin
            mem1[i] = 32'h5A00_0000 | 32'(i * 17);
            refm[i] = 32'h5A00_0000 | 32'(i * 17);
        end
        test_reset();
        test_alternate();
        test_read();
        test_fault();
        test_latency3();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || qa.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got q0=%0d q1=%0d qa=%0d exp=0", q0.size(), q1.size(), qa.size());
        end
        checks++;
        if (tlb_pulses != 2) begin errors++; $display("FAIL tlb_pulse_count got=%0d exp=2", tlb_pulses); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
